// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module : game_pkg
//  Brief  : Shared definitions for the 2048 game blocks. Holds the screen
//           mode encodings and the default PS/2 scan codes. The display and
//           board blocks import the same package.
//  Rev    : 1.0  initial release
// ============================================================================
package game_pkg;

  // Screen/mode encodings. The numeric values are visible on the mode port,
  // so they must not be reordered.
  typedef enum logic [3:0] {
    MODE_TITLE = 4'd0,
    MODE_LOSE  = 4'd1,
    MODE_WIN   = 4'd2,
    MODE_P1    = 4'd3,
    MODE_P2    = 4'd4,
    MODE_PAUSE = 4'd5
  } mode_e;

  // Default PS/2 set-2 make codes.
  localparam logic [7:0] SC_P1    = 8'h16;  // '1'
  localparam logic [7:0] SC_P2    = 8'h1E;  // '2'
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_ENT   = 8'h5A;
  localparam logic [7:0] SC_PAUSE = 8'h4D;  // 'P'

endpackage : game_pkg
`default_nettype wire

// File: rtl/board_scan.sv
`default_nettype none
// ============================================================================
//  Module : board_scan
//  Brief  : Combinational reduction over all board cells: win detection
//           (any exponent >= WIN_EXP), largest exponent, and "no move
//           anywhere" (AND of all per-cell judge bits).
//  Ports  : num_i       packed cell exponents, cell i at [i*CELL_W +: CELL_W]
//           judge_i     per-cell "no legal move" flags
//           any_win_o   some cell has reached WIN_EXP
//           max_exp_o   largest exponent on the board
//           judge_all_o every cell reports no legal move
//  Rev    : 1.0  initial release
// ============================================================================
module board_scan #(
  parameter int unsigned GRID_N  = 4,
  parameter int unsigned CELL_W  = 4,
  parameter int unsigned WIN_EXP = 11
) (
  input  logic [GRID_N*GRID_N*CELL_W-1:0] num_i,
  input  logic [GRID_N*GRID_N-1:0]        judge_i,
  output logic                            any_win_o,
  output logic [CELL_W-1:0]               max_exp_o,
  output logic                            judge_all_o
);

  localparam int unsigned CELLS = GRID_N * GRID_N;

  always_comb begin
    any_win_o = 1'b0;
    max_exp_o = '0;
    for (int i = 0; i < CELLS; i++) begin
      // Widen before comparing so a WIN_EXP beyond the cell range never wins.
      if (32'(num_i[i*CELL_W +: CELL_W]) >= WIN_EXP) begin
        any_win_o = 1'b1;
      end
      if (num_i[i*CELL_W +: CELL_W] > max_exp_o) begin
        max_exp_o = num_i[i*CELL_W +: CELL_W];
      end
    end
  end

  assign judge_all_o = &judge_i;

endmodule : board_scan
`default_nettype wire

// File: rtl/game_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : game_mode_ctrl
//  Brief  : Screen/mode sequencer for the 2048 game: title, play (P1/P2),
//           pause, win and lose. Keys act on their press edge only.
//  Ports  : clk         system clock
//           rst_n       asynchronous active-low reset
//           mode_key_i  current scan code (held while key down, 0 = none)
//           num_i       packed cell exponents
//           judge_i     per-cell "no legal move" flags
//           mode_o      0 title, 1 lose, 2 win, 3 play P1, 4 play P2, 5 pause
//           player_o    last player started (0 = P1, 1 = P2)
//           new_game_o  one-cycle board-clear pulse on title -> play
//           max_exp_o   registered largest exponent on the board
//  Rev    : 1.0  initial release
// ============================================================================
module game_mode_ctrl
  import game_pkg::*;
#(
  parameter int unsigned GRID_N    = 4,
  parameter int unsigned CELL_W    = 4,
  parameter int unsigned WIN_EXP   = 11,
  parameter int unsigned LOSE_CYC  = 4,
  parameter logic [7:0]  KEY_P1    = SC_P1,
  parameter logic [7:0]  KEY_P2    = SC_P2,
  parameter logic [7:0]  KEY_ESC   = SC_ESC,
  parameter logic [7:0]  KEY_ENT   = SC_ENT,
  parameter logic [7:0]  KEY_PAUSE = SC_PAUSE
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      mode_key_i,
  input  logic [GRID_N*GRID_N*CELL_W-1:0] num_i,
  input  logic [GRID_N*GRID_N-1:0]        judge_i,
  output logic [3:0]                      mode_o,
  output logic                            player_o,
  output logic                            new_game_o,
  output logic [CELL_W-1:0]               max_exp_o
);

  localparam int unsigned CNT_W = $clog2(LOSE_CYC + 1);

  mode_e             mode_q, mode_d;
  mode_e             resume_q, resume_d;
  logic              player_q, player_d;
  logic              cont_q, cont_d;
  logic              new_game_q, new_game_d;
  logic [7:0]        key_prev_q;
  logic [CNT_W-1:0]  lose_cnt_q, lose_cnt_d;
  logic [CELL_W-1:0] max_exp_q, max_exp_d;

  logic              any_win;
  logic              judge_all;
  logic [CELL_W-1:0] scan_max;
  logic              key_ev;
  logic              in_play;
  logic              lose_hit;
  logic              start;

  board_scan #(
    .GRID_N  (GRID_N),
    .CELL_W  (CELL_W),
    .WIN_EXP (WIN_EXP)
  ) u_board_scan (
    .num_i       (num_i),
    .judge_i     (judge_i),
    .any_win_o   (any_win),
    .max_exp_o   (scan_max),
    .judge_all_o (judge_all)
  );

  assign key_ev  = (mode_key_i != key_prev_q) && (mode_key_i != 8'h00);
  assign in_play = (mode_q == MODE_P1) || (mode_q == MODE_P2);
  // The current all-ones cycle counts toward LOSE_CYC, so lose lands on the
  // edge that completes the run rather than one cycle later.
  assign lose_hit = judge_all && (lose_cnt_q >= CNT_W'(LOSE_CYC - 1));

  always_comb begin
    mode_d   = mode_q;
    resume_d = resume_q;
    player_d = player_q;
    cont_d   = cont_q;
    start    = 1'b0;

    case (mode_q)
      MODE_TITLE: begin
        if (key_ev && mode_key_i == KEY_P1) begin
          mode_d   = MODE_P1;
          player_d = 1'b0;
          start    = 1'b1;
        end else if (key_ev && mode_key_i == KEY_P2) begin
          mode_d   = MODE_P2;
          player_d = 1'b1;
          start    = 1'b1;
        end
      end
      MODE_P1, MODE_P2: begin
        if (key_ev && mode_key_i == KEY_ESC) begin
          mode_d = MODE_TITLE;
        end else if (key_ev && mode_key_i == KEY_PAUSE) begin
          mode_d   = MODE_PAUSE;
          resume_d = mode_q;
        end else if (any_win && !cont_q) begin
          mode_d = MODE_WIN;
        end else if (lose_hit) begin
          mode_d = MODE_LOSE;
        end
      end
      MODE_PAUSE: begin
        if (key_ev && mode_key_i == KEY_PAUSE) begin
          mode_d = resume_q;
        end else if (key_ev && mode_key_i == KEY_ESC) begin
          mode_d = MODE_TITLE;
        end
      end
      MODE_WIN: begin
        if (key_ev && mode_key_i == KEY_ENT) begin
          mode_d = player_q ? MODE_P2 : MODE_P1;
          cont_d = 1'b1;
        end else if (key_ev && mode_key_i == KEY_ESC) begin
          mode_d = MODE_TITLE;
        end
      end
      MODE_LOSE: begin
        if (key_ev && (mode_key_i == KEY_ENT || mode_key_i == KEY_ESC)) begin
          mode_d = MODE_TITLE;
        end
      end
      default: mode_d = MODE_TITLE;
    endcase

    if (start) begin
      cont_d = 1'b0;
    end

    // Lose run length: tracks judge in play, frozen in pause, zero elsewhere.
    lose_cnt_d = '0;
    if (in_play) begin
      if (judge_all) begin
        lose_cnt_d = (lose_cnt_q == CNT_W'(LOSE_CYC)) ? lose_cnt_q
                                                      : lose_cnt_q + CNT_W'(1);
      end
      if (mode_d == MODE_TITLE || mode_d == MODE_WIN || mode_d == MODE_LOSE) begin
        lose_cnt_d = '0;
      end
    end else if (mode_q == MODE_PAUSE) begin
      lose_cnt_d = lose_cnt_q;
    end

    new_game_d = start;
    if (start) begin
      max_exp_d = '0;
    end else if (in_play) begin
      max_exp_d = scan_max;
    end else begin
      max_exp_d = max_exp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_TITLE;
      resume_q   <= MODE_P1;
      player_q   <= 1'b0;
      cont_q     <= 1'b0;
      new_game_q <= 1'b0;
      key_prev_q <= 8'h00;
      lose_cnt_q <= '0;
      max_exp_q  <= '0;
    end else begin
      mode_q     <= mode_d;
      resume_q   <= resume_d;
      player_q   <= player_d;
      cont_q     <= cont_d;
      new_game_q <= new_game_d;
      key_prev_q <= mode_key_i;
      lose_cnt_q <= lose_cnt_d;
      max_exp_q  <= max_exp_d;
    end
  end

  assign mode_o     = mode_q;
  assign player_o   = player_q;
  assign new_game_o = new_game_q;
  assign max_exp_o  = max_exp_q;

endmodule : game_mode_ctrl
`default_nettype wire

// File: tb/tb_game_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : tb_game_mode_ctrl
//  Brief  : Directed self-checking bench for game_mode_ctrl. A default 4x4
//           instance exercises the screen flow; a 5x5 / WIN_EXP=12 instance
//           checks the generalised win threshold.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_game_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  key;
  logic [63:0] num;
  logic [15:0] judge;
  logic [3:0]  mode;
  logic        player;
  logic        new_game;
  logic [3:0]  max_exp;

  logic [7:0]  key2;
  logic [99:0] num2;
  logic [24:0] judge2;
  logic [3:0]  mode2;
  logic        player2;
  logic        new_game2;
  logic [3:0]  max_exp2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  game_mode_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_key_i (key),
    .num_i      (num),
    .judge_i    (judge),
    .mode_o     (mode),
    .player_o   (player),
    .new_game_o (new_game),
    .max_exp_o  (max_exp)
  );

  game_mode_ctrl #(
    .GRID_N  (5),
    .WIN_EXP (12)
  ) u_dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_key_i (key2),
    .num_i      (num2),
    .judge_i    (judge2),
    .mode_o     (mode2),
    .player_o   (player2),
    .new_game_o (new_game2),
    .max_exp_o  (max_exp2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ng_seen;
    key = 8'h00; num = '0; judge = '0;
    key2 = 8'h00; num2 = '0; judge2 = '0;

    // ---- reset state
    step(); step();
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_player", 32'(player), 32'd0);
    chk("rst_new_game", 32'(new_game), 32'd0);
    chk("rst_max_exp", 32'(max_exp), 32'd0);
    rst_n = 1'b1;
    step();

    // ---- P1 start, key held for 10 cycles
    key = 8'h16;
    step();
    chk("p1_mode", 32'(mode), 32'd3);
    chk("p1_new_game", 32'(new_game), 32'd1);
    chk("p1_player", 32'(player), 32'd0);
    ng_seen = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (new_game) ng_seen++;
    end
    chk("p1_no_retrigger", 32'(ng_seen), 32'd0);
    chk("p1_mode_held", 32'(mode), 32'd3);
    key = 8'h00;
    step();

    // ---- max exponent {3,7,10,2}; 10 is below WIN_EXP so no win
    num[0*4 +: 4]  = 4'd3;
    num[5*4 +: 4]  = 4'd7;
    num[9*4 +: 4]  = 4'd10;
    num[15*4 +: 4] = 4'd2;
    step();
    chk("max_exp_10", 32'(max_exp), 32'd10);
    chk("exp10_no_win", 32'(mode), 32'd3);
    key = 8'h76;
    step();
    chk("esc_to_title", 32'(mode), 32'd0);
    key = 8'h00;
    num = '0;
    step();
    chk("max_held_title", 32'(max_exp), 32'd10);
    key = 8'h16;
    step();
    chk("newgame_max_clr", 32'(max_exp), 32'd0);
    chk("newgame_pulse", 32'(new_game), 32'd1);
    key = 8'h00;
    step();

    // ---- lose: 3 all-ones, a break, then 4 all-ones
    judge = 16'hFFFF;
    step(); step(); step();
    chk("lose_3cyc", 32'(mode), 32'd3);
    judge = 16'hFFFE;
    step();
    chk("lose_break", 32'(mode), 32'd3);
    judge = 16'hFFFF;
    step(); step(); step();
    chk("lose_rerun_3", 32'(mode), 32'd3);
    step();
    chk("lose_4cyc", 32'(mode), 32'd1);
    judge = '0;
    key = 8'h76;
    step();
    chk("lose_esc", 32'(mode), 32'd0);
    key = 8'h00;
    step();

    // ---- P2: win beats lose, continue suppresses win
    key = 8'h1E;
    step();
    chk("p2_mode", 32'(mode), 32'd4);
    chk("p2_player", 32'(player), 32'd1);
    key = 8'h00;
    step();
    num[5*4 +: 4] = 4'd11;
    judge = 16'hFFFF;
    step();
    chk("win_over_lose", 32'(mode), 32'd2);
    judge = '0;
    key = 8'h5A;
    step();
    chk("win_continue", 32'(mode), 32'd4);
    key = 8'h00;
    step(); step(); step();
    chk("win_suppressed", 32'(mode), 32'd4);
    key = 8'h76;
    step();
    chk("p2_esc", 32'(mode), 32'd0);
    key = 8'h00;
    num = '0;
    step();

    // ---- pause freezes the lose run
    key = 8'h16;
    step();
    key = 8'h00;
    judge = 16'hFFFF;
    step(); step();
    key = 8'h4D;
    step();
    chk("pause_enter", 32'(mode), 32'd5);
    key = 8'h00;
    for (int i = 0; i < 10; i++) step();
    chk("pause_hold", 32'(mode), 32'd5);
    key = 8'h4D;
    step();
    chk("pause_resume", 32'(mode), 32'd3);
    key = 8'h00;
    step();
    chk("pause_cnt_kept", 32'(mode), 32'd1);
    judge = '0;
    key = 8'h76;
    step();
    key = 8'h00;
    step();

    // ---- asynchronous reset mid-pause (P2 so player is 1 beforehand)
    key = 8'h1E;
    step();
    key = 8'h00;
    step();
    key = 8'h4D;
    step();
    key = 8'h00;
    chk("pre_rst_pause", 32'(mode), 32'd5);
    chk("pre_rst_player", 32'(player), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_mode", 32'(mode), 32'd0);
    chk("arst_player", 32'(player), 32'd0);
    chk("arst_new_game", 32'(new_game), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_new_game", 32'(new_game), 32'd0);
    chk("post_rst_mode", 32'(mode), 32'd0);

    // ---- 5x5 instance, WIN_EXP = 12 in the last cell
    key2 = 8'h16;
    step();
    chk("g5_start", 32'(mode2), 32'd3);
    key2 = 8'h00;
    num2[24*4 +: 4] = 4'd11;
    step();
    chk("g5_exp11_no_win", 32'(mode2), 32'd3);
    num2[24*4 +: 4] = 4'd12;
    step();
    chk("g5_exp12_win", 32'(mode2), 32'd2);
    chk("g5_max_exp", 32'(max_exp2), 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_game_mode_ctrl
`default_nettype wire
